// File: rtl/demux_1to8_assembler.sv
// demux_1to8_assembler
// Routes a serial bit stream into the positions of an 8-bit word. In
// addressed mode each bit goes to the position given by sel; in auto mode
// positions are taken in order 0..7 from an internal index. A completed word
// is held on out_word/out_valid until the consumer takes it.
module demux_1to8_assembler (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_bit,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] sel,
    input  logic       mode,
    input  logic       flush,
    output logic [7:0] out_word,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_strobe
);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        HOLD
    } state_t;

    state_t     state;
    logic [7:0] shadow;
    logic [7:0] mask;
    logic [2:0] idx;
    logic       word_mode;

    logic       accept;
    logic       eff_mode;
    logic [2:0] pos;
    logic [7:0] pos_hot;
    logic [7:0] shadow_nxt;
    logic [7:0] mask_nxt;
    logic       complete;

    // Accept handshake, write position and completion detection for this cycle.
    // In IDLE the live mode input applies, since word_mode is latched only on
    // this very accept.
    always_comb begin
        in_ready   = (state != HOLD);
        accept     = in_valid && in_ready;
        eff_mode   = (state == IDLE) ? mode : word_mode;
        pos        = eff_mode ? idx : sel;
        pos_hot    = 8'h01 << pos;
        shadow_nxt = in_bit ? (shadow | pos_hot) : (shadow & ~pos_hot);
        mask_nxt   = mask | pos_hot;
        complete   = eff_mode ? (idx == 3'd7) : (mask_nxt == '1);
    end

    // Assembly FSM with registered word, valid and strobe outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shadow     <= '0;
            mask       <= '0;
            idx        <= '0;
            word_mode  <= 1'b0;
            out_word   <= '0;
            out_valid  <= 1'b0;
            out_strobe <= '0;
        end else begin
            out_strobe <= '0;
            case (state)
                IDLE, COLLECT: begin
                    if (flush) begin
                        shadow <= '0;
                        mask   <= '0;
                        idx    <= '0;
                        state  <= IDLE;
                    end else if (accept) begin
                        shadow     <= shadow_nxt;
                        mask       <= mask_nxt;
                        out_strobe <= pos_hot;
                        if (eff_mode) begin
                            idx <= idx + 3'd1;
                        end
                        if (state == IDLE) begin
                            word_mode <= mode;
                        end
                        if (complete) begin
                            out_word  <= shadow_nxt;
                            out_valid <= 1'b1;
                            state     <= HOLD;
                        end else begin
                            state <= COLLECT;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        shadow    <= '0;
                        mask      <= '0;
                        idx       <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_demux_1to8_assembler.sv
// Testbench for demux_1to8_assembler: table-driven addressed-mode vectors,
// hand-written multi-cycle sequences, and a word scoreboard fed at stimulus
// time and drained whenever out_valid rises.
module tb_demux_1to8_assembler;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_bit;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] sel;
    logic       mode;
    logic       flush;
    logic [7:0] out_word;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_strobe;

    int checks   = 0;
    int failures = 0;

    logic [7:0] sb[$];
    logic       prev_v = 1'b0;

    typedef struct {
        logic       valid;
        logic       b;
        logic [2:0] sel;
        logic       mode;
        logic       fl;
        logic       ordy;
        logic       e_rdy;
        logic [7:0] e_strobe;
        logic       e_valid;
        logic [7:0] e_word;
    } vec_t;

    vec_t tbl[10];

    demux_1to8_assembler dut (
        .clk        (clk),
        .rst        (rst),
        .in_bit     (in_bit),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sel        (sel),
        .mode       (mode),
        .flush      (flush),
        .out_word   (out_word),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_strobe (out_strobe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input logic rdy, input logic [7:0] strb,
                           input logic vld, input logic [7:0] wrd);
        chk({name, "_in_ready"}, {7'd0, in_ready}, {7'd0, rdy});
        chk({name, "_strobe"}, out_strobe, strb);
        chk({name, "_out_valid"}, {7'd0, out_valid}, {7'd0, vld});
        chk({name, "_out_word"}, out_word, wrd);
    endtask

    task automatic idle_inputs;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Auto mode: send the low n bits of w LSB-first on consecutive cycles.
    // Pushes w to the scoreboard when the 8th bit is driven.
    task automatic send_auto(input string name, input logic [7:0] w, input int n);
        logic [7:0] hot;
        mode = 1'b1;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_bit   = w[i];
            if (i == 7) sb.push_back(w);
            tick();
            hot = 8'h01 << i;
            chk({name, "_strobe"}, out_strobe, hot);
        end
        in_valid = 1'b0;
    endtask

    // Scoreboard drain: compare each newly presented word.
    always @(posedge clk) begin
        #1;
        if (out_valid && !prev_v) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_word: got unexpected word %h expected none", out_word);
            end else begin
                chk("sb_word", out_word, sb.pop_front());
            end
        end
        prev_v = out_valid;
    end

    initial begin
        rst  = 1'b1;
        sel  = '0;
        mode = 1'b0;
        idle_inputs();

        // Addressed descending sel, ones at 7 and 0, then release and idle.
        for (int i = 0; i < 8; i++) begin
            tbl[i].valid    = 1'b1;
            tbl[i].b        = (i == 0 || i == 7);
            tbl[i].sel      = 3'(7 - i);
            tbl[i].mode     = 1'b0;
            tbl[i].fl       = 1'b0;
            tbl[i].ordy     = 1'b0;
            tbl[i].e_rdy    = (i != 7);
            tbl[i].e_strobe = 8'h80 >> i;
            tbl[i].e_valid  = (i == 7);
            tbl[i].e_word   = (i == 7) ? 8'h81 : 8'h00;
        end
        for (int i = 8; i < 10; i++) begin
            tbl[i].valid    = 1'b0;
            tbl[i].b        = 1'b0;
            tbl[i].sel      = 3'd0;
            tbl[i].mode     = 1'b0;
            tbl[i].fl       = 1'b0;
            tbl[i].ordy     = (i == 8);
            tbl[i].e_rdy    = 1'b1;
            tbl[i].e_strobe = 8'h00;
            tbl[i].e_valid  = 1'b0;
            tbl[i].e_word   = 8'h81;
        end

        // Reset state
        tick();
        tick();
        chk_out("reset", 1'b1, 8'h00, 1'b0, 8'h00);
        rst = 1'b0;
        tick();
        chk_out("post_reset", 1'b1, 8'h00, 1'b0, 8'h00);

        // Table-driven addressed word 8'h81
        for (int i = 0; i < 10; i++) begin
            in_valid  = tbl[i].valid;
            in_bit    = tbl[i].b;
            sel       = tbl[i].sel;
            mode      = tbl[i].mode;
            flush     = tbl[i].fl;
            out_ready = tbl[i].ordy;
            if (tbl[i].e_valid && (i == 0 || !tbl[i-1].e_valid)) sb.push_back(tbl[i].e_word);
            tick();
            chk_out($sformatf("tbl%0d", i), tbl[i].e_rdy, tbl[i].e_strobe, tbl[i].e_valid, tbl[i].e_word);
        end
        idle_inputs();

        // Auto 1,0,1,1,0,0,1,0 -> 4D; mode/sel changes mid-word are ignored
        mode     = 1'b1;
        in_valid = 1'b1;
        in_bit   = 1'b1;
        tick();
        chk("auto_first_strobe", out_strobe, 8'h01);
        mode = 1'b0;
        sel  = 3'd5;
        begin
            logic [7:0] w;
            w = 8'h4D;
            for (int i = 1; i < 8; i++) begin
                in_bit = w[i];
                if (i == 7) sb.push_back(w);
                tick();
                chk("auto_strobe", out_strobe, 8'h01 << i);
            end
        end
        chk_out("auto_4d", 1'b0, 8'h80, 1'b1, 8'h4D);
        in_bit = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("auto_hold", 1'b0, 8'h00, 1'b1, 8'h4D);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk_out("auto_release", 1'b1, 8'h00, 1'b0, 8'h4D);

        // Addressed overwrite of sel 3: 1 then 0, then the other seven -> F7
        mode = 1'b0;
        begin
            logic [2:0] sels[9];
            logic       bits[9];
            sels = '{3'd3, 3'd3, 3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7};
            bits = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
            for (int i = 0; i < 9; i++) begin
                in_valid = 1'b1;
                sel      = sels[i];
                in_bit   = bits[i];
                if (i == 8) sb.push_back(8'hF7);
                tick();
                if (i == 7) chk_out("ovr_8th", 1'b1, 8'h40, 1'b0, 8'h4D);
            end
        end
        in_valid = 1'b0;
        chk_out("ovr_f7", 1'b0, 8'h80, 1'b1, 8'hF7);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Auto: 4 bits, flush with a coincident bit, then A5; flush in HOLD ignored
        send_auto("flush_pre", 8'h0F, 4);
        in_valid = 1'b1;
        in_bit   = 1'b1;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_ready", {7'd0, in_ready}, 8'h01);
        send_auto("a5", 8'hA5, 8);
        chk_out("a5_done", 1'b0, 8'h80, 1'b1, 8'hA5);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk_out("hold_flush", 1'b0, 8'h00, 1'b1, 8'hA5);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset mid-word, then reset during HOLD
        send_auto("rst_pre", 8'h1F, 5);
        do_reset();
        chk_out("rst_mid", 1'b1, 8'h00, 1'b0, 8'h00);
        tick();
        send_auto("w3c", 8'h3C, 8);
        chk_out("w3c_done", 1'b0, 8'h80, 1'b1, 8'h3C);
        do_reset();
        chk_out("rst_hold", 1'b1, 8'h00, 1'b0, 8'h00);
        send_auto("w96", 8'h96, 8);
        chk_out("w96_done", 1'b0, 8'h80, 1'b1, 8'h96);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Back-to-back words with out_ready held high and in_valid always on
        begin
            logic [15:0] stream;
            int          bitn;
            int          vcount;
            logic        acc;
            stream    = 16'hC35A;
            bitn      = 0;
            vcount    = 0;
            mode      = 1'b1;
            out_ready = 1'b1;
            for (int cyc = 0; cyc < 40 && bitn < 16; cyc++) begin
                in_valid = 1'b1;
                in_bit   = stream[bitn];
                acc      = in_ready;
                if (acc && (bitn % 8) == 7) sb.push_back((bitn < 8) ? stream[7:0] : stream[15:8]);
                tick();
                if (out_valid) vcount++;
                if (acc) bitn++;
            end
            in_valid = 1'b0;
            chk("b2b_bits_sent", 8'(bitn), 8'd16);
            for (int i = 0; i < 3; i++) begin
                tick();
                if (out_valid) vcount++;
            end
            chk("b2b_valid_cycles", 8'(vcount), 8'd2);
            out_ready = 1'b0;
        end

        tick();
        chk("sb_empty", 8'(sb.size()), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
